// File: rtl/branch_resolve_unit.sv
// Purpose: sequences one conditional branch. It captures IR and PC, evaluates C2 on R[Ra] as it
//          arrives on BusMuxOut, latches CON, and, when taken, drives a one-cycle PC load of PC + sext(C).
// Latency: after bus_valid is sampled at edge n, a taken branch raises PC_load in cycle n+1 and done
//          in n+2. A not-taken branch raises done in n+1.
// Backpressure: none. start is accepted only in IDLE and WAIT_RA waits indefinitely for bus_valid.
//          abort returns to IDLE from any state, and clear resets asynchronously.
// Ports:
//   clock, clear           rising-edge clock, async active-high reset
//   start, abort           begin a branch (IDLE only) / synchronous cancel
//   IR_in, PC_in           branch instruction (C2 = [20:19], C = [18:0]), incremented PC
//   BusMuxOut, bus_valid   datapath bus carrying R[Ra] and its qualifier
//   busy, CON_out          state != IDLE, latched condition flip-flop
//   PC_load, PC_out        one-cycle PC load strobe, branch target (holds last target)
//   taken, done            completion strobe and its taken flag
module branch_resolve_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 19
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           IR_in,
  input  logic [DATA_WIDTH-1:0] PC_in,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  bus_valid,
  output logic                  busy,
  output logic                  CON_out,
  output logic                  PC_load,
  output logic [DATA_WIDTH-1:0] PC_out,
  output logic                  taken,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_RA = 3'd1,
    S_RESOLVE = 3'd2,
    S_LOAD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_c2;
  logic [OFFSET_WIDTH-1:0] r_c;
  logic [DATA_WIDTH-1:0]   r_pc;
  logic                    r_con;
  logic                    r_pc_load;
  logic [DATA_WIDTH-1:0]   r_pc_out;
  logic                    r_taken;
  logic                    r_done;

  logic                    w_capture;
  logic                    w_eval;
  logic                    w_cond;
  logic [DATA_WIDTH-1:0]   w_target;
  logic                    w_unused_ir;

  // Opcode and register fields of IR belong to the control unit, not to this block.
  assign w_unused_ir = ^IR_in[31:OFFSET_WIDTH+2];

  // The condition is evaluated against the live bus, using the C2 captured at start.
  always_comb begin
    w_cond = 1'b0;
    case (r_c2)
      2'b00:   w_cond = (BusMuxOut == '0);
      2'b01:   w_cond = (BusMuxOut != '0);
      2'b10:   w_cond = ~BusMuxOut[DATA_WIDTH-1];
      default: w_cond =  BusMuxOut[DATA_WIDTH-1];
    endcase
  end

  // Modulo add: wraparound is the intended branch behaviour.
  assign w_target = r_pc + {{(DATA_WIDTH-OFFSET_WIDTH){r_c[OFFSET_WIDTH-1]}}, r_c};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // abort overrides every transition, including start acceptance and bus evaluation.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_eval    = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next    = S_WAIT_RA;
            w_capture = 1'b1;
          end
        end
        S_WAIT_RA: begin
          if (bus_valid) begin
            w_next = S_RESOLVE;
            w_eval = 1'b1;
          end
        end
        S_RESOLVE: w_next = r_con ? S_LOAD : S_DONE;
        S_LOAD:    w_next = S_DONE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_c2 <= '0;
      r_c  <= '0;
      r_pc <= '0;
    end else if (w_capture) begin
      r_c2 <= IR_in[OFFSET_WIDTH+1:OFFSET_WIDTH];
      r_c  <= IR_in[OFFSET_WIDTH-1:0];
      r_pc <= PC_in;
    end
  end

  // CON is only rewritten by a fresh evaluation. abort leaves it alone.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)       r_con <= 1'b0;
    else if (w_eval) r_con <= w_cond;
  end

  // Strobes are registered from the next state, so they coincide exactly with LOAD and DONE.
  // An aborted transition never produces a strobe.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pc_load <= 1'b0;
      r_pc_out  <= '0;
      r_done    <= 1'b0;
      r_taken   <= 1'b0;
    end else begin
      r_pc_load <= (w_next == S_LOAD);
      r_done    <= (w_next == S_DONE);
      r_taken   <= (w_next == S_DONE) && r_con;
      if (w_next == S_LOAD) r_pc_out <= w_target;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign CON_out = r_con;
  assign PC_load = r_pc_load;
  assign PC_out  = r_pc_out;
  assign taken   = r_taken;
  assign done    = r_done;

endmodule
